// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the master and the register-file completer.
// Handshake: a transfer completes on the rising edge where Psel & Penable & Pready are all 1.
interface apb_slave_regfile_if;
  logic       Psel;
  logic       Penable;
  logic       Pwrite;
  logic [3:0] Paddr;
  logic [7:0] PWdata;
  logic [7:0] PRdata;
  logic       Pready;
  logic       Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, PWdata,
    input  PRdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, PWdata,
    output PRdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by DEPTH byte registers, with error response for bad addresses / missing setup.
// Optional macro APB_SLAVE_WAIT_EN inserts WAIT_STATES access cycles with Pready low.
module apb_slave_regfile #(
  parameter int DEPTH       = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic                Pclk,
  input  logic                Preset,
  apb_slave_regfile_if.slave  apb,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  localparam logic [4:0] DEPTH_W = 5'(DEPTH);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] addr_q;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic [7:0] mem [DEPTH];

  logic       access_ready;
  logic       in_range;
  logic       latch;
  logic       commit;

`ifdef APB_SLAVE_WAIT_EN
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
  logic [3:0] cnt;

  assign access_ready = (cnt == WAIT_CNT);

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      cnt <= 4'd0;
    end else if (latch) begin
      cnt <= 4'd0;
    end else if (state == ACCESS && !access_ready && cnt != 4'hF) begin
      cnt <= cnt + 4'd1;
    end
  end
`else
  assign access_ready = 1'b1;
`endif

  assign in_range = ({1'b0, addr_q} < DEPTH_W);

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (apb.Psel && !apb.Penable) begin
          state_nxt = ACCESS;
          latch     = 1'b1;
        end else if (apb.Psel && apb.Penable) begin
          state_nxt = ERR;
        end
      end
      ACCESS: begin
        // Dropping Psel before completion abandons the transfer without a write.
        if (!apb.Psel) begin
          state_nxt = IDLE;
        end else if (apb.Penable && access_ready) begin
          state_nxt = IDLE;
          commit    = wr_q && in_range;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state   <= IDLE;
      addr_q  <= 4'd0;
      wr_q    <= 1'b0;
      wdata_q <= 8'd0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        addr_q  <= apb.Paddr;
        wr_q    <= apb.Pwrite;
        wdata_q <= apb.PWdata;
      end
    end
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
    end else if (commit) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Responses depend only on registered state, never directly on bus inputs.
  always_comb begin
    apb.Pready  = (state == ERR) || (state == ACCESS && access_ready);
    apb.Pslverr = (state == ERR) || (state == ACCESS && access_ready && !in_range);
    apb.PRdata  = 8'd0;
    if (state == ACCESS && access_ready && !wr_q && in_range) apb.PRdata = mem[addr_q];
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomised self-checking bench for apb_slave_regfile against an array-based register model.
module tb_apb_slave_regfile;
  localparam int DEPTH       = 12;
  localparam int WAIT_STATES = 2;
`ifdef APB_SLAVE_WAIT_EN
  localparam int EXP_WAITS = WAIT_STATES;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic       Pclk = 1'b0;
  logic       Preset = 1'b1;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] model_mem [16];
  logic [8:0] exp_q [$];

  apb_slave_regfile_if bus ();

  apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_STATES(WAIT_STATES)) dut (
    .Pclk      (Pclk),
    .Preset    (Preset),
    .apb       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Pclk = ~Pclk;
  always @(posedge Pclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                                     output logic [7:0] exp_rd, output logic exp_err);
    exp_err = (int'(addr) >= DEPTH);
    exp_rd  = 8'h00;
    if (!exp_err) begin
      if (wr) model_mem[addr] = wdata;
      else    exp_rd = model_mem[addr];
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the completing edge with the bus idle.
  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic err, output int waits);
    bus.Psel = 1'b1; bus.Penable = 1'b0;
    bus.Pwrite = wr; bus.Paddr = addr; bus.PWdata = wdata;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    bus.Paddr  = 4'($urandom);
    bus.Pwrite = 1'($urandom);
    bus.PWdata = 8'($urandom);
    waits = 0; rdata = 8'h00; err = 1'b0;
    forever begin
      @(negedge Pclk);
      if (bus.Pready) begin
        rdata = bus.PRdata;
        err   = bus.Pslverr;
        break;
      end
      waits++;
      if (waits >= 20) break;
    end
    @(posedge Pclk); #1;
    bus.Psel = 1'b0; bus.Penable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] rd; logic er; int w;
    bus.Psel = 1'b0; bus.Penable = 1'b0; bus.Pwrite = 1'b0; bus.Paddr = 4'd0; bus.PWdata = 8'd0;
    Preset = 1'b1;
    model_clear();
    repeat (5) begin
      @(negedge Pclk);
      checks++;
      if ({bus.Pready, bus.Pslverr, bus.PRdata} !== 10'h0) begin
        errors++;
        $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h expected 0 0 00", bus.Pready, bus.Pslverr, bus.PRdata);
      end
    end
    @(posedge Pclk); #1;
    Preset = 1'b0;
    @(negedge Pclk);
    checks++;
    if ({bus.Pready, bus.Pslverr, bus.PRdata} !== 10'h0) begin
      errors++;
      $display("FAIL post_reset_outputs: got rdy=%b err=%b rd=%h expected 0 0 00", bus.Pready, bus.Pslverr, bus.PRdata);
    end
    @(posedge Pclk); #1;
    for (int a = 0; a < DEPTH; a++) begin
      apb_xfer(1'b0, 4'(a), 8'h00, rd, er, w);
      checks++;
      if (rd !== 8'h00 || er !== 1'b0) begin
        errors++;
        $display("FAIL reset_mem[%0d]: got %h err=%b expected 00 err=0", a, rd, er);
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd, exp_rd; logic er, exp_er; int w;
    apb_xfer(1'b1, 4'd4, 8'd12, rd, er, w);
    model_xfer(1'b1, 4'd4, 8'd12, exp_rd, exp_er);
    checks++;
    if (w !== EXP_WAITS || er !== exp_er) begin
      errors++;
      $display("FAIL write4: got waits=%0d err=%b expected waits=%0d err=%b", w, er, EXP_WAITS, exp_er);
    end
    apb_xfer(1'b0, 4'd4, 8'h00, rd, er, w);
    model_xfer(1'b0, 4'd4, 8'h00, exp_rd, exp_er);
    checks++;
    if (rd !== exp_rd || er !== exp_er || exp_rd !== 8'd12) begin
      errors++;
      $display("FAIL read4: got %h err=%b expected %h err=%b", rd, er, exp_rd, exp_er);
    end
    apb_xfer(1'b0, 4'd5, 8'h00, rd, er, w);
    model_xfer(1'b0, 4'd5, 8'h00, exp_rd, exp_er);
    checks++;
    if (rd !== exp_rd || er !== exp_er) begin
      errors++;
      $display("FAIL read5: got %h err=%b expected %h err=%b", rd, er, exp_rd, exp_er);
    end
  endtask

  task automatic test_wait_write();
    logic [7:0] rd, exp_rd; logic er, exp_er; int w;
    apb_xfer(1'b1, 4'd9, 8'd255, rd, er, w);
    model_xfer(1'b1, 4'd9, 8'd255, exp_rd, exp_er);
    checks++;
    if (w !== EXP_WAITS || er !== 1'b0) begin
      errors++;
      $display("FAIL wait_write9: got waits=%0d err=%b expected waits=%0d err=0", w, er, EXP_WAITS);
    end
    apb_xfer(1'b0, 4'd9, 8'h00, rd, er, w);
    model_xfer(1'b0, 4'd9, 8'h00, exp_rd, exp_er);
    checks++;
    if (rd !== exp_rd || w !== EXP_WAITS) begin
      errors++;
      $display("FAIL read9: got %h waits=%0d expected %h waits=%0d", rd, w, exp_rd, EXP_WAITS);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd, exp_rd; logic er, exp_er; int w;
    apb_xfer(1'b1, 4'd14, 8'hAA, rd, er, w);
    model_xfer(1'b1, 4'd14, 8'hAA, exp_rd, exp_er);
    checks++;
    if (er !== 1'b1 || er !== exp_er || w !== EXP_WAITS) begin
      errors++;
      $display("FAIL oor_write: got err=%b waits=%0d expected err=1 waits=%0d", er, w, EXP_WAITS);
    end
    apb_xfer(1'b0, 4'd14, 8'h00, rd, er, w);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL oor_read: got err=%b rd=%h expected err=1 rd=00", er, rd);
    end
    for (int a = 0; a < DEPTH; a++) begin
      apb_xfer(1'b0, 4'(a), 8'h00, rd, er, w);
      model_xfer(1'b0, 4'(a), 8'h00, exp_rd, exp_er);
      checks++;
      if (rd !== exp_rd || er !== 1'b0) begin
        errors++;
        $display("FAIL oor_mem[%0d]: got %h err=%b expected %h err=0", a, rd, er, exp_rd);
      end
    end
  endtask

  task automatic test_no_setup();
    logic [7:0] rd, exp_rd; logic er, exp_er; int w;
    bus.Psel = 1'b1; bus.Penable = 1'b1; bus.Pwrite = 1'b1; bus.Paddr = 4'd2; bus.PWdata = 8'hEE;
    @(negedge Pclk);
    checks++;
    if (bus.Pready !== 1'b0) begin
      errors++;
      $display("FAIL nosetup_pre: got rdy=%b expected 0", bus.Pready);
    end
    @(posedge Pclk); #1;
    @(negedge Pclk);
    checks++;
    if (bus.Pready !== 1'b1 || bus.Pslverr !== 1'b1) begin
      errors++;
      $display("FAIL nosetup_err: got rdy=%b err=%b expected 1 1", bus.Pready, bus.Pslverr);
    end
    @(posedge Pclk); #1;
    bus.Psel = 1'b0; bus.Penable = 1'b0;
    @(negedge Pclk);
    checks++;
    if (bus.Pready !== 1'b0 || bus.Pslverr !== 1'b0) begin
      errors++;
      $display("FAIL nosetup_oneshot: got rdy=%b err=%b expected 0 0", bus.Pready, bus.Pslverr);
    end
    @(posedge Pclk); #1;
    apb_xfer(1'b0, 4'd2, 8'h00, rd, er, w);
    model_xfer(1'b0, 4'd2, 8'h00, exp_rd, exp_er);
    checks++;
    if (rd !== exp_rd || er !== exp_er) begin
      errors++;
      $display("FAIL nosetup_mem2: got %h expected %h", rd, exp_rd);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd, exp_rd; logic er, exp_er; int w;
    apb_xfer(1'b1, 4'd3, 8'h33, rd, er, w);
    model_xfer(1'b1, 4'd3, 8'h33, exp_rd, exp_er);
    bus.Psel = 1'b1; bus.Penable = 1'b0; bus.Pwrite = 1'b1; bus.Paddr = 4'd3; bus.PWdata = 8'hCC;
    @(posedge Pclk); #1;
    bus.Psel = 1'b0; bus.Penable = 1'b0;
    @(posedge Pclk); #1;
    @(posedge Pclk); #1;
    apb_xfer(1'b0, 4'd3, 8'h00, rd, er, w);
    model_xfer(1'b0, 4'd3, 8'h00, exp_rd, exp_er);
    checks++;
    if (rd !== exp_rd || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_mem3: got %h err=%b expected %h err=0", rd, er, exp_rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd, exp_rd; logic er, exp_er; int w;
    bus.Psel = 1'b1; bus.Penable = 1'b0; bus.Pwrite = 1'b1; bus.Paddr = 4'd7; bus.PWdata = 8'h77;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    #2 Preset = 1'b1;
    #1;
    checks++;
    if ({bus.Pready, bus.Pslverr, bus.PRdata} !== 10'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b err=%b rd=%h expected 0 0 00", bus.Pready, bus.Pslverr, bus.PRdata);
    end
    @(posedge Pclk); #1;
    bus.Psel = 1'b0; bus.Penable = 1'b0;
    @(posedge Pclk); #1;
    Preset = 1'b0;
    model_clear();
    @(posedge Pclk); #1;
    apb_xfer(1'b0, 4'd7, 8'h00, rd, er, w);
    checks++;
    if (rd !== 8'h00 || er !== 1'b0) begin
      errors++;
      $display("FAIL midreset_mem7: got %h err=%b expected 00 err=0", rd, er);
    end
    apb_xfer(1'b0, 4'd4, 8'h00, rd, er, w);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL midreset_mem4: got %h expected 00", rd);
    end
    apb_xfer(1'b1, 4'd7, 8'h5A, rd, er, w);
    model_xfer(1'b1, 4'd7, 8'h5A, exp_rd, exp_er);
    apb_xfer(1'b0, 4'd7, 8'h00, rd, er, w);
    model_xfer(1'b0, 4'd7, 8'h00, exp_rd, exp_er);
    checks++;
    if (rd !== exp_rd || w !== EXP_WAITS) begin
      errors++;
      $display("FAIL midreset_recover: got %h waits=%0d expected %h waits=%0d", rd, w, exp_rd, EXP_WAITS);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd, exp_rd; logic er, exp_er; int w, c0, span;
    logic [7:0] d;
    d  = 8'($urandom_range(1, 255));
    c0 = cyc;
    apb_xfer(1'b1, 4'd6, d, rd, er, w);
    model_xfer(1'b1, 4'd6, d, exp_rd, exp_er);
    apb_xfer(1'b0, 4'd6, 8'h00, rd, er, w);
    model_xfer(1'b0, 4'd6, 8'h00, exp_rd, exp_er);
    span = cyc - c0;
    checks++;
    if (rd !== exp_rd) begin
      errors++;
      $display("FAIL b2b_data: got %h expected %h", rd, exp_rd);
    end
    checks++;
    if (span !== 2 * (EXP_WAITS + 2)) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d expected %0d", span, 2 * (EXP_WAITS + 2));
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, exp_rd, wd; logic er, exp_er, wr; logic [3:0] a; int w;
    logic [8:0] exp;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom);
      a  = 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      model_xfer(wr, a, wd, exp_rd, exp_er);
      exp_q.push_back({exp_er, exp_rd});
      apb_xfer(wr, a, wd, rd, er, w);
      exp = exp_q.pop_front();
      checks++;
      if ({er, rd} !== exp || w !== EXP_WAITS) begin
        errors++;
        $display("FAIL random[%0d] wr=%b addr=%0d: got err=%b rd=%h waits=%0d expected err=%b rd=%h waits=%0d",
                 n, wr, a, er, rd, w, exp[8], exp[7:0], EXP_WAITS);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge Pclk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_write();
    test_out_of_range();
    test_no_setup();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer sitting directly downstream of the APB master.
- Consumes the master's Psel/Penable/Paddr/PWdata/Pwrite and returns PRdata/Pready/Pslverr.
- Backs a small 8-bit register file, inserts a configurable number of wait states, and flags out-of-range addresses and protocol violations via Pslverr.

Parameters:
- DEPTH, 12, number of implemented byte registers (addresses 0..DEPTH-1); legal range 1..16.
- WAIT_STATES, 2, access-phase cycles with Pready low before completion; only used when APB_SLAVE_WAIT_EN is defined.

Ports:
- Pclk  input  1  bus clock; all state updates on the rising edge.
- Preset  input  1  asynchronous, active-high reset.
- Psel  input  1  slave select from master.
- Penable  input  1  access-phase indicator from master.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  4  register address.
- PWdata  input  8  write data.
- PRdata  output  8  read data; valid only while Pready=1 and the transfer is a read.
- Pready  output  1  transfer completes on the rising edge where Psel&Penable&Pready=1.
- Pslverr  output  1  error response; meaningful only while Pready=1.

Behaviour:
- Interface: one clock (Pclk); reset Preset is asynchronous, active-high.
- Reset: state=IDLE, wait counter=0, all DEPTH registers=8'h00, addr_q/wr_q/wdata_q=0. PRdata=8'h00, Pready=0, Pslverr=0 while Preset is high and in the first cycle after release.
- FSM states:
  - IDLE: on a rising edge with Psel=1 and Penable=0 (setup phase), latch Paddr→addr_q, Pwrite→wr_q, PWdata→wdata_q, clear cnt, go to ACCESS.
  - IDLE with Psel=1 and Penable=1 (access without setup) → go to ERR.
  - ACCESS: Pready = (cnt == WAIT_STATES). Each edge with Pready=0 increments cnt (saturating at 15).
    - Edge with Psel&Penable&Pready: commit, then go to IDLE.
    - Psel=0 in ACCESS: abort, no write, go to IDLE.
  - ERR: Pready=1 and Pslverr=1 for one cycle, no memory effect, then IDLE.
- Pready, Pslverr and PRdata are decoded from registered state only. There is no combinational path from bus inputs to outputs.
- Address check: addr_q >= DEPTH → Pslverr=1 in the completing cycle. An errored write leaves memory unchanged; an errored read returns PRdata=8'h00.
- Write commit: mem[addr_q] <= wdata_q on the completing edge. The stored value is the one sampled at setup; PWdata changes during ACCESS are ignored.
- Read: PRdata = mem[addr_q] while state=ACCESS and Pready=1 and wr_q=0; otherwise 8'h00.
- Paddr/Pwrite changes during ACCESS are ignored.
- Back-to-back transfers: the completing edge goes to IDLE. The next setup phase is sampled on the following edge; there is no dead cycle beyond the APB setup cycle.
- A write then a read of the same address in consecutive transfers returns the new value.
- Reset asserted mid-transfer: immediate return to reset values. The pending write is discarded and the register contents are cleared.

Optional Feature:
- Macro: APB_SLAVE_WAIT_EN.
- Defined: wait-state counter present; Pready is held low for WAIT_STATES access cycles, then goes high.
- Undefined: counter omitted; Pready=1 in the first access cycle (zero-wait). WAIT_STATES is ignored.
- All other behaviour is identical in both builds.

Test Plan:
- Zero-wait write: with the macro undefined, reset for 5 cycles, then setup Paddr=4, PWdata=12, Pwrite=1. Required: Pready=1 in the first access cycle, Pslverr=0, mem[4]=12 after completion.
- Wait-state write: with the macro defined and WAIT_STATES=2, write Paddr=9, PWdata=255. Required: Pready low for exactly 2 access cycles, high on the 3rd, mem[9]=255.
- Reads: read Paddr=4, then Paddr=5 (unwritten). Required: PRdata=12 then 8'h00 on the completing cycles, Pslverr=0 for both.
- Out-of-range access: with DEPTH=12, write Paddr=14, PWdata=8'hAA, then read Paddr=14. Required: Pslverr=1 with Pready on both, no register changed, PRdata=8'h00.
- Protocol violations:
  - Psel=1 and Penable=1 from IDLE with no setup cycle. Required: one-cycle Pready=1, Pslverr=1, memory untouched.
  - Psel dropped mid-ACCESS on a write to address 3. Required: mem[3] unchanged.
- Reset mid-transfer: assert Preset during the ACCESS wait of a write to address 7. Required: outputs go to zero immediately, mem[7]=0, and the next transfer works normally.
